// File: rtl/spike_inference_ctrl.sv
// Inference sequencer for the SNN core: buffers input samples, paces them into
// the core on request, counts output spikes and reports the argmax class.
module spike_inference_ctrl #(
  parameter int unsigned IN_W       = 8,
  parameter int unsigned OUT_N      = 2,
  parameter int unsigned CLS_W      = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned N_SAMPLES  = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             net_start,
  input  logic             net_ready,
  input  logic             net_sample,
  output logic             net_sample_ready,
  output logic [IN_W-1:0]  net_in_spikes,
  input  logic [OUT_N-1:0] net_out_spikes,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CLS_W-1:0] res_class,
  output logic [CNT_W-1:0] res_count,
  output logic             busy,
  output logic             err_underrun
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(N_SAMPLES + 1);

  typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q [OUT_N];
  logic [CNT_W-1:0] cnt_d [OUT_N];
  logic             err_q, err_d;
  logic [CLS_W-1:0] res_class_q, res_class_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic [CLS_W-1:0] best_idx;
  logic [CNT_W-1:0] best_cnt;

  logic empty, full, push, pop, underrun;

  assign empty    = (occ_q == '0);
  assign full     = (occ_q == OCC_W'(FIFO_DEPTH));
  assign push     = s_valid && !full;
  assign pop      = (state_q == RUN) && net_sample && !empty;
  assign underrun = (state_q == RUN) && net_sample && empty;

  assign s_ready          = !full;
  assign net_in_spikes    = empty ? '0 : mem_q[rd_ptr_q];
  assign net_sample_ready = (state_q == RUN) && !empty;
  assign net_start        = (state_q == START);
  assign res_valid        = (state_q == DONE);
  assign busy             = (state_q != IDLE);
  assign err_underrun     = err_q;
  assign res_class        = res_class_q;
  assign res_count        = res_count_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    err_d       = err_q | underrun;
    res_class_d = res_class_q;
    res_count_d = res_count_q;
    best_idx    = '0;
    best_cnt    = '0;

    if (state_q == RUN || state_q == DRAIN) begin
      for (int unsigned i = 0; i < OUT_N; i++) begin
        if (net_out_spikes[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    // Argmax runs on the updated counts so a spike in the final DRAIN cycle is included;
    // strict compare keeps the lowest index on ties.
    for (int unsigned i = 0; i < OUT_N; i++) begin
      if (cnt_d[i] > best_cnt) begin
        best_cnt = cnt_d[i];
        best_idx = CLS_W'(i);
      end
    end

    case (state_q)
      IDLE: if (!empty && net_ready) state_d = START;
      START: begin
        idx_d = '0;
        for (int unsigned i = 0; i < OUT_N; i++) cnt_d[i] = '0;
        state_d = RUN;
      end
      RUN: begin
        if (pop) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(N_SAMPLES - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (net_ready) begin
          res_class_d = best_idx;
          res_count_d = best_cnt;
          state_d     = DONE;
        end
      end
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      res_class_q <= '0;
      res_count_q <= '0;
      for (int unsigned i = 0; i < OUT_N; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      res_class_q <= res_class_d;
      res_count_q <= res_count_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
